branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Fetch-side branch prediction unit. It is the consumer of the `BResult` correction bundle that EXE-stage branch resolution emits, and the producer of the `PResult` bundle that travels down the pipeline with each instruction. It contains a direct-mapped BTB with 2-bit saturating counters and a speculative return-address stack (RAS). The stack has a committed-pointer shadow for recovery. It sits beside the IF-stage PC register and delivers one registered prediction per accepted fetch.

## Interface
Parameters:
- `ENTRIES`, 64: number of BTB entries (power of two). `IDXW = $clog2(ENTRIES)`.
- `RAS_DEPTH`, 8: number of RAS entries (power of two).

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `IF_Req` in 1: fetch lookup request for `IF_PC`.
- `IF_Stall` in 1: IF stage held; the lookup is not accepted.
- `IF_PC` in 32: fetch PC (word aligned).
- `IF_PResult` out `PResult`: registered prediction {`Valid`, `Hit`, `Type`, `Target`, `Count`}.
- `EXE_BResult` in `BResult`: resolution bundle {`Valid`, `PC`, `Type`, `IsTaken`, `Target`, `Count`, `Hit`}.
- `EXE_Prediction_Failed` in 1: the EXE stage detected a misprediction.
- `EXE_PF_FlushAll` in 1: the predicted instruction turned out to be a non-branch.

## Operation
- Index and tag:
  - index = `PC[IDXW+1:2]`
  - tag = `PC[31:IDXW+2]`
- BTB entry fields: `valid`, `tag`, `type` (3 bits), `target` (32 bits), `cnt` (2 bits).
- Lookup accept condition: `IF_Req && !IF_Stall`.
- Lookup result, computed on an accepted lookup:
  - Hit: `valid` is set and the tags match. On a hit, `Type` = `type` and `Count` = `cnt`.
  - Miss: `Type`=`BIsNone`, `Count`=2'b01, `Target`=PC+8.
  - Target by type on a hit:
    - `BIsBran`: `Target` = `target` if `cnt[1]`, else PC+8.
    - `BIsJump` and `BIsCall`: `Target` = `target`.
    - `BIsRetn`: `Target` = RAS top if the RAS is non-empty, else `target`.
- Speculative RAS actions, on an accepted hit:
  - `BIsCall`: push PC+8.
  - `BIsRetn` with the RAS non-empty: pop.
- Update, when `EXE_BResult.Valid` is high:
  - Write the entry at `BResult.PC`'s index: `valid`=1, tag, and `type`=`BResult.Type`.
  - `target`: write `BResult.Target` if `IsTaken`, or on a miss (`!BResult.Hit`). Otherwise keep the old value.
  - `cnt` on a hit: saturating increment if taken, saturating decrement if not taken, starting from `BResult.Count`.
  - `cnt` on a miss: 2'b10 if taken, 2'b01 if not taken.
- Invalidate: when `EXE_PF_FlushAll` is high, clear `valid` at `BResult.PC`'s index if the tag matches. This takes precedence over an update to the same entry.
- Committed RAS pointer, driven by `EXE_BResult.Valid`:
  - `Type`=`BIsCall`: increment the pointer and write `BResult.PC`+8 into the slot.
  - `Type`=`BIsRetn`: decrement the pointer, saturating at empty.
- Recovery: when `EXE_Prediction_Failed | EXE_PF_FlushAll` is high, the speculative pointer and count are loaded from the committed values *after* the same-cycle commit update. Stack contents are not restored.
- RAS boundaries:
  - The RAS is circular. A push when full overwrites the oldest entry; the count saturates at `RAS_DEPTH`.
  - A pop when empty leaves the pointer and count unchanged.
  - A push and a recovery in the same cycle: recovery wins.

## Timing
- Lookup latency is 1 cycle: accepted in cycle t, `IF_PResult` is valid at the rising edge ending t.
- While `IF_Stall` is high:
  - `IF_PResult` holds its value.
  - No RAS action occurs.
- When `IF_Req` is low and `IF_Stall` is low, `IF_PResult.Valid` goes to 0 on the next edge. The other fields are don't-care.
- The update is written at the end of the cycle in which `BResult.Valid` is high.
- A same-cycle lookup and update of the same index returns the pre-update contents (read-before-write). A lookup in the next cycle sees the new entry.
- Reset (async, `resetn`=0):
  - All BTB `valid` bits cleared, all `cnt` = 2'b01.
  - RAS pointers and counts = 0.
  - `IF_PResult` = all zeros.
- A reset mid-operation discards all state immediately.

## Structure
- Shared package / `CPU_Defines.svh` holds:
  - the `PResult` and `BResult` structs;
  - the `BIsNone`, `BIsBran`, `BIsJump`, `BIsCall`, `BIsRetn` encodings;
  - the 2-bit counter constants.
- Sub-module `return_addr_stack`:
  - speculative pointer and committed pointer;
  - push/pop/commit/recover ports;
  - exposes `top` and `empty`.
- The BTB is a flop array inside `branch_predict_unit`. It is written on update, and read combinationally into the output register.

## Test plan
- Reset; lookup PC 0x8000_0000 -> next cycle `Valid`=1, `Hit`=0, `Type`=`BIsNone`, `Target`=0x8000_0008, `Count`=01.
- Taken `BIsBran` update {PC=0x8000_0100, Target=0x8000_0200, miss} then lookup 0x8000_0100 -> `Hit`=1, `Count`=10, `Target`=0x8000_0200. Then two not-taken updates -> `Count`=00, `Target`=0x8000_0108.
- A lookup in the same cycle as the update to the same index returns the miss. A lookup one cycle later returns the hit.
- Calls at 0x100, 0x200, then a `BIsRetn` lookup -> `Target`=0x208, then 0x108.
  - Push 9 calls with `RAS_DEPTH`=8 -> the oldest is overwritten.
  - Pop when empty -> BTB `target` is used.
- Speculative call push, then `EXE_Prediction_Failed` with no commits -> the RAS is empty. A return lookup returns BTB `target`.
- `EXE_PF_FlushAll` with matching `BResult.PC` -> the next lookup misses. Hold `IF_Stall`=1 for 3 cycles -> `IF_PResult` is unchanged. Assert `resetn` low mid-stream -> the outputs are zero at once.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_pkg
// Shared types for fetch-side branch prediction: the branch-type encodings,
// the 2-bit saturating counter constants, the PResult bundle that travels
// with each fetched instruction and the BResult bundle that EXE-stage branch
// resolution sends back.
// ---------------------------------------------------------------------------
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    BIsNone = 3'd0,
    BIsBran = 3'd1,
    BIsJump = 3'd2,
    BIsCall = 3'd3,
    BIsRetn = 3'd4
  } btype_e;

  // 2-bit counter states; bit 1 is the taken/not-taken prediction.
  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  typedef struct packed {
    logic        Valid;
    logic        Hit;
    btype_e      Type;
    logic [31:0] Target;
    logic [1:0]  Count;
  } PResult;

  typedef struct packed {
    logic        Valid;
    logic [31:0] PC;
    btype_e      Type;
    logic        IsTaken;
    logic [31:0] Target;
    logic [1:0]  Count;
    logic        Hit;
  } BResult;

  // Saturating step of a 2-bit counter towards taken or not-taken.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_STRONG_T) ? cnt : cnt + 2'd1;
    return (cnt == CNT_STRONG_NT) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_ras.sv
// ---------------------------------------------------------------------------
// return_addr_stack
// Circular return-address stack with a speculative pointer (moved by fetch
// lookups) and a committed pointer (moved by resolved calls/returns). On
// recovery the speculative pointer/count are reloaded from the committed
// ones as they stand after this cycle's commit; contents are not restored.
// Ports:
//   clk, resetn              clock, async active-low reset
//   push, push_data          speculative push of a return address
//   pop                      speculative pop (ignored when empty)
//   commit_push, commit_data resolved call: advance committed ptr, write slot
//   commit_pop               resolved return: retreat committed ptr (sat.)
//   recover                  reload speculative state from committed state
//   top, empty               speculative top-of-stack and empty flag
// ---------------------------------------------------------------------------
module return_addr_stack
  import branch_predict_unit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        commit_push,
  input  logic        commit_pop,
  input  logic [31:0] commit_data,
  input  logic        recover,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] spec_ptr, commit_ptr, commit_ptr_next;
  logic [PW:0]   spec_cnt, commit_cnt, commit_cnt_next;

  // Committed state after this cycle's resolution; recovery loads from here.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    commit_ptr_next = commit_ptr;
    commit_cnt_next = commit_cnt;
    if (commit_push) begin
      commit_ptr_next = commit_ptr + PW'(1);
      commit_cnt_next = (commit_cnt == FULL) ? FULL : commit_cnt + (PW+1)'(1);
    end else if (commit_pop && commit_cnt != '0) begin
      commit_ptr_next = commit_ptr - PW'(1);
      commit_cnt_next = commit_cnt - (PW+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_ptr   <= '0;
      spec_cnt   <= '0;
      commit_ptr <= '0;
      commit_cnt <= '0;
    end else begin
      commit_ptr <= commit_ptr_next;
      commit_cnt <= commit_cnt_next;
      if (recover) begin
        spec_ptr <= commit_ptr_next;
        spec_cnt <= commit_cnt_next;
      end else if (push) begin
        // Full stack wraps onto the oldest entry; count saturates.
        spec_ptr <= spec_ptr + PW'(1);
        spec_cnt <= (spec_cnt == FULL) ? FULL : spec_cnt + (PW+1)'(1);
      end else if (pop && spec_cnt != '0) begin
        spec_ptr <= spec_ptr - PW'(1);
        spec_cnt <= spec_cnt - (PW+1)'(1);
      end
    end
  end

  // NOTE: the storage array is not reset; the count gates every read, so
  // stale contents are never observed and the array stays plain flops/RAM.
  // A speculative push is newer than any same-cycle commit, so it is written
  // last and wins a slot collision.
  always_ff @(posedge clk) begin
    if (commit_push)         mem[commit_ptr] <= commit_data;
    if (push && !recover)    mem[spec_ptr]   <= push_data;
  end

  assign top   = mem[spec_ptr - PW'(1)];
  assign empty = (spec_cnt == '0);

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Fetch-side predictor: direct-mapped BTB with 2-bit counters plus a
// speculative return-address stack. One registered PResult per accepted
// fetch; BTB trained from the EXE-stage BResult bundle.
// Ports:
//   clk, resetn            clock, async active-low reset
//   IF_Req, IF_Stall       lookup request / IF hold (lookup accepted when
//                          IF_Req && !IF_Stall)
//   IF_PC                  fetch PC (word aligned)
//   IF_PResult             registered prediction
//   EXE_BResult            branch resolution / BTB update bundle
//   EXE_Prediction_Failed  misprediction: recover the RAS
//   EXE_PF_FlushAll        predicted instruction was not a branch:
//                          invalidate its BTB entry and recover the RAS
// ---------------------------------------------------------------------------
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_Req,
  input  logic        IF_Stall,
  input  logic [31:0] IF_PC,
  output PResult      IF_PResult,
  input  BResult      EXE_BResult,
  input  logic        EXE_Prediction_Failed,
  input  logic        EXE_PF_FlushAll
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 32 - IDXW - 2;

  // BTB flop array
  logic [ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]    btb_tag    [ENTRIES];
  btype_e             btb_type   [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [1:0]         btb_cnt    [ENTRIES];

  // Lookup side
  logic [IDXW-1:0] rd_idx;
  logic [TAGW-1:0] rd_tag;
  logic [31:0]     pc_plus8;
  logic            rd_hit;
  logic            accept;
  PResult          lookup;
  logic            ras_push, ras_pop;
  logic [31:0]     ras_top;
  logic            ras_empty;

  // Update side
  logic [IDXW-1:0] wr_idx;
  logic [TAGW-1:0] wr_tag;
  logic [1:0]      wr_cnt;
  logic            wr_target_en;
  logic            flush_hit;
  logic            commit_push, commit_pop, recover;

  assign rd_idx   = IF_PC[IDXW+1:2];
  assign rd_tag   = IF_PC[31:IDXW+2];
  assign pc_plus8 = IF_PC + 32'd8;
  assign accept   = IF_Req && !IF_Stall;
  assign rd_hit   = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);

  always_comb begin
    lookup        = '0;
    lookup.Valid  = 1'b1;
    lookup.Hit    = rd_hit;
    lookup.Type   = BIsNone;
    lookup.Target = pc_plus8;
    lookup.Count  = CNT_WEAK_NT;
    if (rd_hit) begin
      lookup.Type  = btb_type[rd_idx];
      lookup.Count = btb_cnt[rd_idx];
      case (btb_type[rd_idx])
        BIsBran:          lookup.Target = btb_cnt[rd_idx][1] ? btb_target[rd_idx] : pc_plus8;
        BIsJump, BIsCall: lookup.Target = btb_target[rd_idx];
        BIsRetn:          lookup.Target = ras_empty ? btb_target[rd_idx] : ras_top;
        default:          lookup.Target = pc_plus8;
      endcase
    end
  end

  assign ras_push = accept && rd_hit && (btb_type[rd_idx] == BIsCall);
  assign ras_pop  = accept && rd_hit && (btb_type[rd_idx] == BIsRetn) && !ras_empty;

  // Output register: holds during a stall, drops Valid when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        IF_PResult <= '0;
    else if (!IF_Stall) IF_PResult <= IF_Req ? lookup : '0;
  end

  // Resolution side
  assign wr_idx       = EXE_BResult.PC[IDXW+1:2];
  assign wr_tag       = EXE_BResult.PC[31:IDXW+2];
  assign wr_target_en = EXE_BResult.IsTaken || !EXE_BResult.Hit;
  // Matches against the stored tag as it stands before this cycle's write.
  assign flush_hit    = EXE_PF_FlushAll && (btb_tag[wr_idx] == wr_tag);

  always_comb begin
    if (EXE_BResult.Hit) wr_cnt = cnt_step(EXE_BResult.Count, EXE_BResult.IsTaken);
    else                 wr_cnt = EXE_BResult.IsTaken ? CNT_WEAK_T : CNT_WEAK_NT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) btb_cnt[i] <= CNT_WEAK_NT;
    end else begin
      if (EXE_BResult.Valid) begin
        btb_valid[wr_idx] <= 1'b1;
        btb_cnt[wr_idx]   <= wr_cnt;
      end
      // Invalidate is written last so it overrides a same-entry update.
      if (flush_hit) btb_valid[wr_idx] <= 1'b0;
    end
  end

  // Payload fields are qualified by btb_valid and need no reset.
  always_ff @(posedge clk) begin
    if (EXE_BResult.Valid) begin
      btb_tag[wr_idx]  <= wr_tag;
      btb_type[wr_idx] <= EXE_BResult.Type;
      if (wr_target_en) btb_target[wr_idx] <= EXE_BResult.Target;
    end
  end

  assign commit_push = EXE_BResult.Valid && (EXE_BResult.Type == BIsCall);
  assign commit_pop  = EXE_BResult.Valid && (EXE_BResult.Type == BIsRetn);
  assign recover     = EXE_Prediction_Failed || EXE_PF_FlushAll;

  return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .resetn      (resetn),
    .push        (ras_push),
    .push_data   (pc_plus8),
    .pop         (ras_pop),
    .commit_push (commit_push),
    .commit_pop  (commit_pop),
    .commit_data (EXE_BResult.PC + 32'd8),
    .recover     (recover),
    .top         (ras_top),
    .empty       (ras_empty)
  );

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Self-checking bench for branch_predict_unit. A reference model keeps the
// BTB as slots holding the full branch PC and the RAS as an array with
// integer pointers/counts, advanced once per clock edge from the same
// inputs the DUT sees.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int ENTRIES   = 64;
  localparam int RAS_DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        IF_Req, IF_Stall;
  logic [31:0] IF_PC;
  PResult      IF_PResult;
  BResult      EXE_BResult;
  logic        EXE_Prediction_Failed, EXE_PF_FlushAll;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .IF_Req                (IF_Req),
    .IF_Stall              (IF_Stall),
    .IF_PC                 (IF_PC),
    .IF_PResult            (IF_PResult),
    .EXE_BResult           (EXE_BResult),
    .EXE_Prediction_Failed (EXE_Prediction_Failed),
    .EXE_PF_FlushAll       (EXE_PF_FlushAll)
  );

  // ---------------- reference model ----------------
  bit          m_v       [ENTRIES];
  bit          m_written [ENTRIES];
  bit [31:0]   m_pc      [ENTRIES];
  btype_e      m_ty      [ENTRIES];
  bit [31:0]   m_tgt     [ENTRIES];
  bit [1:0]    m_cnt     [ENTRIES];
  bit [31:0]   m_stack   [RAS_DEPTH];
  int          m_sp, m_sc, m_cp, m_cc;
  PResult      m_pres;

  function automatic int slot(input bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic PResult mk(input bit v, input bit h, input btype_e t,
                                input bit [31:0] tg, input bit [1:0] c);
    PResult p;
    p.Valid = v; p.Hit = h; p.Type = t; p.Target = tg; p.Count = c;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i]   = 1'b0;
      m_cnt[i] = 2'b01;
    end
    m_sp = 0; m_sc = 0; m_cp = 0; m_cc = 0;
    m_pres = '0;
  endtask

  task automatic model_edge();
    PResult    nxt;
    int        s, w, c, ncp, ncc;
    bit        hit, do_push, do_pop, fl;
    bit [31:0] top, pc8;
    s   = slot(IF_PC);
    hit = m_v[s] && (m_pc[s] == IF_PC);
    pc8 = IF_PC + 32'd8;
    top = m_stack[(m_sp + RAS_DEPTH - 1) % RAS_DEPTH];
    nxt = m_pres;
    if (!IF_Stall) begin
      if (!IF_Req) nxt = '0;
      else if (!hit) nxt = mk(1, 0, BIsNone, pc8, 2'b01);
      else begin
        nxt = mk(1, 1, m_ty[s], pc8, m_cnt[s]);
        if (m_ty[s] == BIsBran && m_cnt[s] >= 2) nxt.Target = m_tgt[s];
        if (m_ty[s] == BIsJump || m_ty[s] == BIsCall) nxt.Target = m_tgt[s];
        if (m_ty[s] == BIsRetn) nxt.Target = (m_sc > 0) ? top : m_tgt[s];
      end
    end
    do_push = IF_Req && !IF_Stall && hit && m_ty[s] == BIsCall;
    do_pop  = IF_Req && !IF_Stall && hit && m_ty[s] == BIsRetn && m_sc > 0;
    // committed stack
    ncp = m_cp; ncc = m_cc;
    if (EXE_BResult.Valid && EXE_BResult.Type == BIsCall) begin
      m_stack[m_cp] = EXE_BResult.PC + 32'd8;
      ncp = (m_cp + 1) % RAS_DEPTH;
      ncc = (m_cc < RAS_DEPTH) ? m_cc + 1 : RAS_DEPTH;
    end else if (EXE_BResult.Valid && EXE_BResult.Type == BIsRetn && m_cc > 0) begin
      ncp = (m_cp + RAS_DEPTH - 1) % RAS_DEPTH;
      ncc = m_cc - 1;
    end
    // speculative stack
    if (EXE_Prediction_Failed || EXE_PF_FlushAll) begin
      m_sp = ncp; m_sc = ncc;
    end else if (do_push) begin
      m_stack[m_sp] = pc8;
      m_sp = (m_sp + 1) % RAS_DEPTH;
      m_sc = (m_sc < RAS_DEPTH) ? m_sc + 1 : RAS_DEPTH;
    end else if (do_pop) begin
      m_sp = (m_sp + RAS_DEPTH - 1) % RAS_DEPTH;
      m_sc = m_sc - 1;
    end
    m_cp = ncp; m_cc = ncc;
    // BTB
    w  = slot(EXE_BResult.PC);
    fl = EXE_PF_FlushAll && (m_pc[w] == EXE_BResult.PC);
    if (EXE_BResult.Valid) begin
      m_v[w] = 1; m_written[w] = 1;
      m_pc[w] = EXE_BResult.PC;
      m_ty[w] = EXE_BResult.Type;
      if (EXE_BResult.IsTaken || !EXE_BResult.Hit) m_tgt[w] = EXE_BResult.Target;
      if (EXE_BResult.Hit) begin
        c = EXE_BResult.Count;
        if (EXE_BResult.IsTaken) c = (c == 3) ? 3 : c + 1;
        else                     c = (c == 0) ? 0 : c - 1;
        m_cnt[w] = 2'(c);
      end else begin
        m_cnt[w] = EXE_BResult.IsTaken ? 2'b10 : 2'b01;
      end
    end
    if (fl) m_v[w] = 0;
    m_pres = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    IF_Req = 0; IF_Stall = 0; IF_PC = '0;
    EXE_BResult = '0; EXE_Prediction_Failed = 0; EXE_PF_FlushAll = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    IF_Req = 1; IF_PC = pc;
  endtask

  task automatic upd(input logic [31:0] pc, input btype_e ty, input logic taken,
                     input logic [31:0] tgt, input logic [1:0] cnt, input logic hit);
    EXE_BResult.Valid = 1; EXE_BResult.PC = pc; EXE_BResult.Type = ty;
    EXE_BResult.IsTaken = taken; EXE_BResult.Target = tgt;
    EXE_BResult.Count = cnt; EXE_BResult.Hit = hit;
  endtask

  task automatic pulse_reset();
    resetn = 0;
    model_reset();
    #2;
    resetn = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (IF_PResult !== PResult'('0)) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", IF_PResult);
    end
    resetn = 1;
  endtask

  task automatic test_miss();
    PResult exp;
    idle(); look(32'h8000_0000); tick();
    exp = mk(1, 0, BIsNone, 32'h8000_0008, 2'b01);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL miss_lookup: got %h expected %h", IF_PResult, exp);
    end
    idle(); tick();
    n_cmp++;
    if (IF_PResult.Valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid: got %b expected 0", IF_PResult.Valid);
    end
  endtask

  task automatic test_bran();
    PResult exp;
    // same-cycle update and lookup of the same index: pre-update contents
    idle(); upd(32'h8000_0100, BIsBran, 1, 32'h8000_0200, 2'b01, 0);
    look(32'h8000_0100); tick();
    exp = mk(1, 0, BIsNone, 32'h8000_0108, 2'b01);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL rbw_miss: got %h expected %h", IF_PResult, exp);
    end
    idle(); look(32'h8000_0100); tick();
    exp = mk(1, 1, BIsBran, 32'h8000_0200, 2'b10);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL bran_taken: got %h expected %h", IF_PResult, exp);
    end
    idle(); upd(32'h8000_0100, BIsBran, 0, 32'h8000_0108, 2'b10, 1); tick();
    idle(); upd(32'h8000_0100, BIsBran, 0, 32'h8000_0108, 2'b01, 1); tick();
    idle(); look(32'h8000_0100); tick();
    exp = mk(1, 1, BIsBran, 32'h8000_0108, 2'b00);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL bran_not_taken: got %h expected %h", IF_PResult, exp);
    end
  endtask

  task automatic test_ras();
    PResult exp;
    idle(); upd(32'h100, BIsCall, 1, 32'h4000, 2'b01, 0); tick();
    idle(); look(32'h100); tick();
    exp = mk(1, 1, BIsCall, 32'h4000, 2'b10);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL call_lookup: got %h expected %h", IF_PResult, exp);
    end
    idle(); upd(32'h200, BIsCall, 1, 32'h5000, 2'b01, 0); tick();
    idle(); look(32'h200); tick();
    idle(); upd(32'h304, BIsRetn, 1, 32'h6000, 2'b01, 0); tick();
    idle(); look(32'h304); tick();
    n_cmp++;
    if (IF_PResult.Target !== 32'h208) begin
      n_fail++; $display("FAIL ret_first: got %h expected 00000208", IF_PResult.Target);
    end
    idle(); look(32'h304); tick();
    n_cmp++;
    if (IF_PResult.Target !== 32'h108) begin
      n_fail++; $display("FAIL ret_second: got %h expected 00000108", IF_PResult.Target);
    end
    idle(); look(32'h304); tick();
    n_cmp++;
    if (IF_PResult.Target !== 32'h6000) begin
      n_fail++; $display("FAIL ret_empty: got %h expected 00006000", IF_PResult.Target);
    end
    // nine pushes into an eight-deep stack, then nine returns
    idle(); upd(32'h108, BIsCall, 1, 32'h7000, 2'b01, 0); tick();
    for (int i = 0; i < 9; i++) begin
      idle(); look((i % 2 == 0) ? 32'h200 : 32'h108); tick();
      n_cmp++;
      if (IF_PResult !== m_pres) begin
        n_fail++; $display("FAIL push_%0d: got %h expected %h", i, IF_PResult, m_pres);
      end
    end
    for (int i = 0; i < 9; i++) begin
      idle(); look(32'h304); tick();
      n_cmp++;
      if (IF_PResult !== m_pres) begin
        n_fail++; $display("FAIL pop_%0d: got %h expected %h", i, IF_PResult, m_pres);
      end
    end
    n_cmp++;
    if (IF_PResult.Target !== 32'h6000) begin
      n_fail++; $display("FAIL overflow_oldest_lost: got %h expected 00006000", IF_PResult.Target);
    end
    idle();
  endtask

  task automatic test_recover();
    idle(); #2; pulse_reset();
    idle(); upd(32'h200, BIsCall, 1, 32'h5000, 2'b01, 0); tick();
    idle(); upd(32'h304, BIsRetn, 1, 32'h6000, 2'b01, 0); tick();
    idle(); look(32'h200); tick();
    idle(); EXE_Prediction_Failed = 1; tick();
    idle(); look(32'h304); tick();
    n_cmp++;
    if (IF_PResult.Target !== 32'h6000) begin
      n_fail++; $display("FAIL recover_empty: got %h expected 00006000", IF_PResult.Target);
    end
    // push and recovery in the same cycle: the push is discarded
    idle(); look(32'h200); EXE_Prediction_Failed = 1; tick();
    idle(); look(32'h304); tick();
    n_cmp++;
    if (IF_PResult.Target !== 32'h6000) begin
      n_fail++; $display("FAIL push_vs_recover: got %h expected 00006000", IF_PResult.Target);
    end
    idle();
  endtask

  task automatic test_flush_stall();
    PResult exp;
    idle(); upd(32'h8000_0400, BIsJump, 1, 32'h8000_9000, 2'b01, 0); tick();
    idle(); look(32'h8000_0400); tick();
    exp = mk(1, 1, BIsJump, 32'h8000_9000, 2'b10);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL jump_hit: got %h expected %h", IF_PResult, exp);
    end
    idle(); EXE_PF_FlushAll = 1; EXE_BResult.PC = 32'h8000_0400; tick();
    idle(); look(32'h8000_0400); tick();
    exp = mk(1, 0, BIsNone, 32'h8000_0408, 2'b01);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL flush_miss: got %h expected %h", IF_PResult, exp);
    end
    for (int i = 0; i < 3; i++) begin
      idle(); IF_Stall = 1; look(32'h8000_0100); tick();
      n_cmp++;
      if (IF_PResult !== exp) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h expected %h", i, IF_PResult, exp);
      end
    end
    idle();
  endtask

  task automatic test_random();
    bit [31:0] pool [12] = '{32'h1000, 32'h1004, 32'h1008, 32'h2000, 32'h2004, 32'h3008,
                             32'h100C, 32'h2010, 32'h4000, 32'h4004, 32'h500C, 32'h6010};
    PResult got;
    for (int n = 0; n < 600; n++) begin
      idle();
      IF_Req   = ($urandom % 4) != 0;
      IF_Stall = ($urandom % 5) == 0;
      IF_PC    = pool[$urandom % 12];
      if ($urandom % 2 == 0) begin
        upd(pool[$urandom % 12], btype_e'(3'($urandom_range(1, 4))), 1'($urandom),
            {$urandom_range(0, 32'h0FFF_FFFF), 2'b00}, 2'($urandom), 1'($urandom));
      end else begin
        EXE_BResult.PC = pool[$urandom % 12];
      end
      EXE_Prediction_Failed = ($urandom % 10) == 0;
      EXE_PF_FlushAll = (($urandom % 12) == 0) && m_written[slot(EXE_BResult.PC)];
      tick();
      got = IF_PResult;
      if (!m_pres.Valid) begin
        got.Hit = 0; got.Type = BIsNone; got.Target = '0; got.Count = '0;
      end
      n_cmp++;
      if (got !== m_pres) begin
        n_fail++; $display("FAIL random_%0d: got %h expected %h", n, got, m_pres);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    PResult exp;
    idle(); look(32'h8000_0100); tick();
    n_cmp++;
    if (IF_PResult !== m_pres) begin
      n_fail++; $display("FAIL pre_reset: got %h expected %h", IF_PResult, m_pres);
    end
    resetn = 0;
    model_reset();
    #1;
    n_cmp++;
    if (IF_PResult !== PResult'('0)) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0", IF_PResult);
    end
    #2;
    resetn = 1;
    idle(); look(32'h8000_0100); tick();
    exp = mk(1, 0, BIsNone, 32'h8000_0108, 2'b01);
    n_cmp++;
    if (IF_PResult !== exp) begin
      n_fail++; $display("FAIL post_reset_miss: got %h expected %h", IF_PResult, exp);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_bran();
    test_ras();
    test_recover();
    test_flush_stall();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
